// File: rtl/sync_pkg.sv
// ============================================================================
// Module      : sync_pkg
// Description : Shared types and helpers for the synchronization link:
//               transmitter state encoding and counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_pkg;

  // Transmitter states; PARITY is only entered when SYNC_TX_PARITY_EN is set.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } tx_state_e;

  // Width of a counter holding values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_gap_timer.sv
// ============================================================================
// Module      : sync_gap_timer
// Description : Loadable down-counter timing the idle gap between words.
//               Loads GAP_CYCLES-1, counts down on request and holds at zero;
//               terminal count is flagged while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_gap_timer
  import sync_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_tc
);

  localparam int GW = cnt_width(GAP_CYCLES + 1);
  // The load cycle itself is the first gap cycle, hence GAP_CYCLES-1.
  localparam logic [GW-1:0] c_load = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [GW-1:0] r_count;

  // Load on request, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= c_load;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - GW'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/sync_tx_serializer.sv
// ============================================================================
// Module      : sync_tx_serializer
// Description : Parallel-to-serial transmitter, MSB first, with bit strobe,
//               done pulse on the last bit and a programmable idle gap.
//               Optional even-parity bit enabled by macro SYNC_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_tx_serializer
  import sync_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  fastClk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  dataValid,
  output logic                  dataReady,
  output logic                  serialOut,
  output logic                  enable,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] c_last_idx = BW'(DATA_WIDTH - 1);
  // State that follows the last transmitted bit of a word.
  localparam tx_state_e c_after_word = (GAP_CYCLES == 0) ? IDLE : GAP;
  localparam logic c_use_gap = (GAP_CYCLES > 0);

  tx_state_e             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [BW-1:0]         r_bitcnt, w_bitcnt_nxt;
  logic                  r_ser, w_ser_nxt;
  logic                  r_en, w_en_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_gap_load, w_gap_dec, w_gap_tc;
`ifdef SYNC_TX_PARITY_EN
  logic                  r_parity, w_parity_nxt;
`endif

  // Next-state and next-output decode. Outputs are registered, so each branch
  // computes what the line shows in the following cycle; the MSB goes out
  // straight from dataIn at the handshake and the shift register keeps the rest.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_ser_nxt    = 1'b0;
    w_en_nxt     = 1'b0;
    w_done_nxt   = 1'b0;
    w_gap_load   = 1'b0;
    w_gap_dec    = 1'b0;
`ifdef SYNC_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      IDLE: begin
        if (dataValid) begin
          w_state_nxt  = SHIFT;
          w_shreg_nxt  = dataIn << 1;
          w_bitcnt_nxt = c_last_idx;
          w_ser_nxt    = dataIn[DATA_WIDTH-1];
          w_en_nxt     = 1'b1;
`ifdef SYNC_TX_PARITY_EN
          w_parity_nxt = ^dataIn;
`else
          w_done_nxt   = (DATA_WIDTH == 1);
`endif
        end
      end
      SHIFT: begin
        if (r_bitcnt != '0) begin
          w_ser_nxt    = r_shreg[DATA_WIDTH-1];
          w_en_nxt     = 1'b1;
          w_shreg_nxt  = r_shreg << 1;
          w_bitcnt_nxt = r_bitcnt - BW'(1);
`ifndef SYNC_TX_PARITY_EN
          w_done_nxt   = (r_bitcnt == BW'(1));
`endif
        end else begin
`ifdef SYNC_TX_PARITY_EN
          w_state_nxt = PARITY;
          w_ser_nxt   = r_parity;
          w_en_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
`else
          w_state_nxt = c_after_word;
          w_gap_load  = c_use_gap;
`endif
        end
      end
      PARITY: begin
`ifdef SYNC_TX_PARITY_EN
        w_state_nxt = c_after_word;
        w_gap_load  = c_use_gap;
`else
        w_state_nxt = IDLE;
`endif
      end
      GAP: begin
        if (w_gap_tc) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered output updates; reset aborts any word.
  always_ff @(posedge fastClk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_ser    <= 1'b0;
      r_en     <= 1'b0;
      r_done   <= 1'b0;
`ifdef SYNC_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_ser    <= w_ser_nxt;
      r_en     <= w_en_nxt;
      r_done   <= w_done_nxt;
`ifdef SYNC_TX_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  sync_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk   (fastClk),
    .rst   (reset),
    .i_load(w_gap_load),
    .i_dec (w_gap_dec),
    .o_tc  (w_gap_tc)
  );

  assign dataReady = (r_state == IDLE) && !reset;
  assign busy      = (r_state != IDLE);
  assign serialOut = r_ser;
  assign enable    = r_en;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sync_tx_serializer.sv
// ============================================================================
// Module      : tb_sync_tx_serializer
// Description : Self-checking bench for sync_tx_serializer. Two instances:
//               A (4-bit word, 2 gap cycles) and B (1-bit word, no gap).
//               Follows SYNC_TX_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_tx_serializer;

  localparam int WA = 4;
  localparam int GA = 2;
  localparam int WB = 1;
  localparam int GB = 0;
`ifdef SYNC_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int PERA = 1 + WA + P + GA;

  logic fastClk = 1'b0;
  always #5 fastClk = ~fastClk;

  logic          rstA = 1'b1, vA = 1'b0, rstB = 1'b1, vB = 1'b0;
  logic [WA-1:0] dA = '0;
  logic [WB-1:0] dB = '0;
  logic rdyA, serA, enA, busyA, doneA;
  logic rdyB, serB, enB, busyB, doneB;

  sync_tx_serializer #(.DATA_WIDTH(WA), .GAP_CYCLES(GA)) u_dut_a (
    .fastClk(fastClk), .reset(rstA), .dataIn(dA), .dataValid(vA),
    .dataReady(rdyA), .serialOut(serA), .enable(enA), .busy(busyA), .done(doneA)
  );

  sync_tx_serializer #(.DATA_WIDTH(WB), .GAP_CYCLES(GB)) u_dut_b (
    .fastClk(fastClk), .reset(rstB), .dataIn(dB), .dataValid(vB),
    .dataReady(rdyB), .serialOut(serB), .enable(enB), .busy(busyB), .done(doneB)
  );

  // Expected strobed bit: owning instance, cycle it must appear in, value, done.
  typedef struct {
    int inst;
    int cyc;
    bit val;
    bit dn;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   ready_at[2] = '{0, 0};
  bit   exp_ready[2] = '{0, 0};
  bit   exp_busy[2] = '{0, 0};
  bit   chk[2] = '{0, 0};
  bit   seen_rst[2] = '{0, 0};
  int   total = 0;
  int   bad = 0;

  always @(posedge fastClk) cyc <= cyc + 1;

  // Reference model: a word accepted in cycle k owns the line for the next
  // w (+parity) cycles, then g idle cycles, and the block is ready again after.
  task automatic model_step(input int n, input int k, input bit v,
                            input logic [WA-1:0] d, input bit r,
                            input int w, input int g);
    chk[n]       = seen_rst[n];
    exp_ready[n] = !r && (k >= ready_at[n]);
    exp_busy[n]  = (k < ready_at[n]);
    if (r) begin
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].inst == n && sb[i].cyc > k) sb.delete(i);
      ready_at[n] = k + 1;
      seen_rst[n] = 1'b1;
    end else if (v && (k >= ready_at[n])) begin
      for (int i = 0; i < w; i++)
        sb.push_back('{n, k + 1 + i, d[w-1-i], (i == w - 1) && (P == 0)});
      if (P == 1) sb.push_back('{n, k + w + 1, ^d, 1'b1});
      ready_at[n] = k + 1 + w + P + g;
    end
  endtask

  // One clock cycle of stimulus for both instances.
  task automatic drive(input bit va, input logic [WA-1:0] da, input bit ra,
                       input bit vb, input logic [WB-1:0] db, input bit rb);
    @(posedge fastClk);
    #1;
    vA = va; dA = da; rstA = ra;
    vB = vb; dB = db; rstB = rb;
    model_step(0, cyc, va, da, ra, WA, GA);
    model_step(1, cyc, vb, {{(WA-WB){1'b0}}, db}, rb, WB, GB);
  endtask

  task automatic cmp(input int n, input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL inst%0d %s cyc=%0d got=%0d want=%0d", n, name, cyc, got, want);
    end
  endtask

  // Monitor: per-cycle handshake/busy checks, and a scoreboard pop whenever a
  // strobed bit is presented.
  task automatic check_inst(input int n);
    logic en, ser, dn, rdy, bsy;
    int   idx;
    en  = (n == 0) ? enA   : enB;
    ser = (n == 0) ? serA  : serB;
    dn  = (n == 0) ? doneA : doneB;
    rdy = (n == 0) ? rdyA  : rdyB;
    bsy = (n == 0) ? busyA : busyB;
    idx = -1;
    cmp(n, "dataReady", {31'd0, rdy}, {31'd0, exp_ready[n]});
    cmp(n, "busy", {31'd0, bsy}, {31'd0, exp_busy[n]});
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].inst == n) begin
        idx = i;
        break;
      end
    if (en === 1'b1) begin
      if (idx < 0) begin
        total++;
        bad++;
        $display("FAIL inst%0d unexpected_strobe cyc=%0d got=ser%b want=no strobe", n, cyc, ser);
      end else begin
        cmp(n, "bit_cycle", cyc, sb[idx].cyc);
        cmp(n, "serialOut", {31'd0, ser}, {31'd0, sb[idx].val});
        cmp(n, "done", {31'd0, dn}, {31'd0, sb[idx].dn});
        sb.delete(idx);
      end
    end else begin
      cmp(n, "enable", {31'd0, en}, 32'd0);
      cmp(n, "idle_serialOut", {31'd0, ser}, 32'd0);
      cmp(n, "idle_done", {31'd0, dn}, 32'd0);
      if (idx >= 0 && sb[idx].cyc <= cyc) begin
        total++;
        bad++;
        $display("FAIL inst%0d missing_bit cyc=%0d got=no strobe want=bit %0d", n, cyc, sb[idx].val);
        sb.delete(idx);
      end
    end
  endtask

  always @(negedge fastClk) begin
    for (int n = 0; n < 2; n++)
      if (chk[n]) check_inst(n);
  end

  initial begin
    // Reset both instances.
    drive(0, '0, 1, 0, '0, 1);
    drive(0, '0, 1, 0, '0, 1);
    drive(0, '0, 0, 0, '0, 0);
    drive(0, '0, 0, 0, '0, 0);

    // Single word 1011 on A; B sends 1,0,1 back-to-back with valid held high.
    drive(1, 4'b1011, 0, 1, 1'b1, 0);
    drive(0, 4'h0, 0, 1, 1'b0, 0);
    drive(0, 4'h0, 0, 1, 1'b0, 0);
    drive(1, 4'h3, 0, 1, 1'b1, 0);  // A busy: pulse with 3 must be ignored
    drive(0, 4'h0, 0, 1, 1'b1, 0);
    drive(0, 4'h0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 6; i++) drive(0, 4'h0, 0, 0, '0, 0);

    // Valid held high: word A then word 5.
    drive(1, 4'hA, 0, 0, '0, 0);
    for (int i = 0; i < PERA; i++) drive(1, 4'h5, 0, 0, '0, 0);
    for (int i = 0; i < PERA + 2; i++) drive(0, 4'h0, 0, 0, '0, 0);

    // Reset in the second cycle of word F.
    drive(1, 4'hF, 0, 0, '0, 0);
    drive(0, 4'h0, 0, 0, '0, 0);
    drive(0, 4'h0, 1, 0, '0, 0);
    for (int i = 0; i < 3; i++) drive(0, 4'h0, 0, 0, '0, 0);

    // Reset and valid together: word must not be captured.
    drive(1, 4'h9, 1, 1, 1'b1, 1);
    for (int i = 0; i < 3; i++) drive(0, 4'h0, 0, 0, '0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 3) != 0, 4'($urandom), ($urandom % 60) == 0,
            ($urandom % 2) != 0, 1'($urandom), ($urandom % 60) == 0);
    end

    // Drain and confirm nothing expected is left outstanding.
    for (int i = 0; i < PERA + 4; i++) drive(0, 4'h0, 0, 0, '0, 0);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_empty got=%0d pending want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_tx_serializer.md
# sync_tx_serializer

Parallel-to-serial transmitter that drives the single-bit, strobe-qualified input of the team's synchronization register. It accepts a DATA_WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per cycle, with a bit-valid strobe. It then holds the line idle for a programmable number of gap cycles before accepting the next word. It sits on the sending side of the link, in the same clock domain as the receiving register.

## Interface
- DATA_WIDTH, 4, word width in bits; must be >= 1.
- GAP_CYCLES, 2, idle cycles inserted after each word; must be >= 0.
- fastClk  input  1  clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- dataIn  input  DATA_WIDTH  parallel word to send; sampled only on handshake.
- dataValid  input  1  word on dataIn is valid.
- dataReady  output  1  block can accept a word.
- serialOut  output  1  serial data, MSB first; 0 when enable is low.
- enable  output  1  bit strobe; serialOut is meaningful when high.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on the final transmitted bit of a word.

## Operation
- States: IDLE, SHIFT, PARITY (only with the macro), GAP.
- **IDLE**
  - dataReady = 1.
  - On dataValid && dataReady: load dataIn into the shift register, load the bit counter with DATA_WIDTH-1, go to SHIFT.
- **SHIFT**
  - Each cycle: enable=1, serialOut=shift register MSB, shift left by one, decrement the bit counter.
  - At counter 0:
    - go to PARITY if the macro is defined;
    - otherwise go to GAP, or to IDLE if GAP_CYCLES=0.
- **PARITY**
  - One cycle: enable=1, serialOut = XOR of the captured word (even parity).
  - Next state is GAP, or IDLE if GAP_CYCLES=0.
- **GAP**
  - enable=0, serialOut=0.
  - Counts GAP_CYCLES cycles, then goes to IDLE.
- done is high in the cycle that drives the last bit: the LSB without the macro, the parity bit with it.
- dataValid outside IDLE is ignored. The bench must not rely on dataIn being held after the handshake.
- Counter widths:
  - bit counter: max(1, $clog2(DATA_WIDTH));
  - gap counter: max(1, $clog2(GAP_CYCLES+1)).
  - No wrap-around beyond terminal counts.
- DATA_WIDTH=1: SHIFT lasts exactly one cycle.

## Timing
- serialOut, enable and done are registered outputs. dataReady and busy decode from the state register. dataReady is also forced to 0 while reset is high.
- Handshake accepted at the edge ending cycle T:
  - bits appear in cycles T+1 .. T+DATA_WIDTH;
  - parity bit, if enabled, in T+DATA_WIDTH+1;
  - then GAP_CYCLES idle cycles;
  - dataReady returns high in the next cycle.
- Word period is 1 + DATA_WIDTH (+1 with parity) + GAP_CYCLES cycles. A continuously asserted dataValid achieves this rate.
- Reset values: state=IDLE, shift register 0, counters 0, serialOut=0, enable=0, done=0, busy=0. dataReady=0 while reset is high and 1 in the first cycle after release.
- Reset during SHIFT, PARITY or GAP:
  - the word is aborted;
  - all outputs take their reset values at that edge;
  - no done pulse is produced.
- Reset and dataValid high in the same cycle: reset wins and the word is not captured.

## Configuration
- Macro: SYNC_TX_PARITY_EN.
- Defined: the PARITY state exists and one even-parity bit (strobed) follows each word. Word period grows by one cycle.
- Undefined: no PARITY state and no parity logic. done accompanies the LSB.

## Structure
- Shared package sync_pkg holds:
  - the tx_state_e enum (IDLE, SHIFT, PARITY, GAP);
  - a localparam helper for counter widths.
- The receiving synchronization register does not use sync_pkg.
- One sub-module: sync_gap_timer, a loadable down-counter with a terminal-count output, parameterized by GAP_CYCLES.
- Shift register and FSM stay in the top module.

## Test plan
- DATA_WIDTH=4, GAP_CYCLES=2, macro off; dataIn=4'b1011 accepted at cycle 0 -> serialOut 1,0,1,1 with enable=1 in cycles 1-4; done in cycle 4; dataReady=0 in cycles 1-6 and 1 in cycle 7.
- Same stimulus with SYNC_TX_PARITY_EN defined -> parity bit 1 with enable=1 and done in cycle 5; dataReady high again in cycle 8.
- dataValid held high with words 4'hA then 4'h5 -> second word's bits 0,1,0,1 start in cycle 8 (macro off); exactly one done per word.
- Reset asserted in cycle 2 of a 4'hF word -> in cycle 3 enable=0, serialOut=0, busy=0, no done; dataReady=1 once reset is released.
- GAP_CYCLES=0, DATA_WIDTH=1, back-to-back words 1,0,1 -> serialOut 1,0,1 in cycles 1,3,5 with a handshake every 2 cycles.
- dataValid pulsed with 4'h3 while busy -> ignored; transmitted bits unchanged and no extra word sent.
